// File: rtl/gaussian_window_ctrl.sv
`default_nettype none
// ============================================================================
//  gaussian_window_ctrl : raster-to-3x3 zero-padded window sequencer feeding
//  gaussian_filter. Optional macro GAUSS_CTRL_ERR_EN adds a sticky err flag.
//  Revision 1.0
// ============================================================================
module gaussian_window_ctrl #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic        clk,
   input  logic        rstN,
   input  logic        start,
   input  logic [7:0]  pix_in,
   input  logic        pix_in_valid,
   output logic        pix_in_ready,
   output logic [71:0] window_out,
   output logic        window_out_valid,
   input  logic        filt_valid,
   output logic        busy,
   output logic        frame_done
`ifdef GAUSS_CTRL_ERR_EN
   ,
   output logic        err
`endif
);

   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam int OW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH);
   localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
   localparam logic [OW-1:0] PIX_TOTAL = OW'(IMG_WIDTH * IMG_HEIGHT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   row_q, row_d;
   logic [CW-1:0]   col_q, col_d;
   logic [OW-1:0]   cnt_q, cnt_d;
   logic [71:0]     window_out_q, window_out_d;
   logic            window_out_valid_q, window_out_valid_d;
`ifdef GAUSS_CTRL_ERR_EN
   logic            err_q, err_d;
`endif

   logic            proc_en;
   logic            emit;
   logic [7:0]      pixel;
   logic [7:0]      line0_q [IMG_WIDTH+1];
   logic [7:0]      line1_q [IMG_WIDTH+1];
   logic [7:0]      win_q   [3][3];
   logic [7:0]      win_d   [3][3];
   logic [7:0]      col_new [3];
   logic [71:0]     win_masked;

   // FSM, position counters and output counter
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      cnt_d        = cnt_q;
      proc_en      = 1'b0;
      pixel        = 8'd0;
      pix_in_ready = 1'b0;
      frame_done   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               row_d   = '0;
               col_d   = '0;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (col_q != COL_LAST) begin
               pix_in_ready = 1'b1;
               proc_en      = pix_in_valid;
               pixel        = pix_in;
            end else begin
               proc_en = 1'b1;
            end
         end
         S_FLUSH: proc_en = 1'b1;
         S_DRAIN: begin
            if (cnt_q == PIX_TOTAL) begin
               frame_done = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (proc_en) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            if (state_q == S_RUN) begin
               row_d = row_q + RW'(1);
               if (row_q == ROW_LAST) state_d = S_FLUSH;
            end else begin
               state_d = S_DRAIN;
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end

      if (state_q != S_IDLE && filt_valid) cnt_d = cnt_q + OW'(1);
   end

   // Window shift and zero-padding of the emitted copy
   always_comb begin
      col_new[0] = line1_q[col_q];
      col_new[1] = line0_q[col_q];
      col_new[2] = pixel;
      if (col_q == COL_LAST) begin
         col_new[0] = 8'd0;
         col_new[1] = 8'd0;
         col_new[2] = 8'd0;
      end
      for (int rr = 0; rr < 3; rr++) begin
         win_d[rr][0] = win_q[rr][1];
         win_d[rr][1] = win_q[rr][2];
         win_d[rr][2] = col_new[rr];
      end
      win_masked = '0;
      for (int rr = 0; rr < 3; rr++) begin
         for (int cc = 0; cc < 3; cc++) begin
            if (!((rr == 0 && row_q == RW'(1)) || (cc == 0 && col_q == CW'(1))))
               win_masked[(rr*3+cc)*8 +: 8] = win_d[rr][cc];
         end
      end
      emit               = proc_en && (row_q != '0) && (col_q != '0);
      window_out_valid_d = emit;
      window_out_d       = emit ? win_masked : window_out_q;
`ifdef GAUSS_CTRL_ERR_EN
      err_d = err_q | (start && state_q != S_IDLE) | (filt_valid && state_q == S_IDLE);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q            <= S_IDLE;
         row_q              <= '0;
         col_q              <= '0;
         cnt_q              <= '0;
         window_out_q       <= '0;
         window_out_valid_q <= 1'b0;
`ifdef GAUSS_CTRL_ERR_EN
         err_q              <= 1'b0;
`endif
      end else begin
         state_q            <= state_d;
         row_q              <= row_d;
         col_q              <= col_d;
         cnt_q              <= cnt_d;
         window_out_q       <= window_out_d;
         window_out_valid_q <= window_out_valid_d;
`ifdef GAUSS_CTRL_ERR_EN
         err_q              <= err_d;
`endif
      end
   end

   // Data storage needs no reset: stale contents are masked by the padding rule
   always_ff @(posedge clk) begin
      if (proc_en) begin
         line1_q[col_q] <= line0_q[col_q];
         line0_q[col_q] <= pixel;
         for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
               win_q[rr][cc] <= win_d[rr][cc];
            end
         end
      end
   end

   assign window_out       = window_out_q;
   assign window_out_valid = window_out_valid_q;
   assign busy             = (state_q != S_IDLE);
`ifdef GAUSS_CTRL_ERR_EN
   assign err              = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gaussian_window_ctrl.sv
`default_nettype none
// Bench for gaussian_window_ctrl: 4x3 frames, 3-cycle filter valid model,
// windows checked against a neighbourhood model of the image.
module tb_gaussian_window_ctrl;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  pix_in = 8'd0;
   logic        pix_in_valid = 1'b0;
   logic        pix_in_ready;
   logic [71:0] window_out;
   logic        window_out_valid;
   logic        filt_valid;
   logic        busy;
   logic        frame_done;
`ifdef GAUSS_CTRL_ERR_EN
   logic        err;
`endif

   gaussian_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk              (clk),
      .rstN             (rstN),
      .start            (start),
      .pix_in           (pix_in),
      .pix_in_valid     (pix_in_valid),
      .pix_in_ready     (pix_in_ready),
      .window_out       (window_out),
      .window_out_valid (window_out_valid),
      .filt_valid       (filt_valid),
      .busy             (busy),
      .frame_done       (frame_done)
`ifdef GAUSS_CTRL_ERR_EN
      ,
      .err              (err)
`endif
   );

   always #5 clk = ~clk;

   // Stand-in for gaussian_filter's valid path: three register stages
   logic [2:0] fv_pipe = 3'b000;
   always @(posedge clk) begin
      if (!rstN) fv_pipe <= 3'b000;
      else       fv_pipe <= {fv_pipe[1:0], window_out_valid};
   end
   assign filt_valid = fv_pipe[2];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [71:0] wins[$];
   bit          rdy_log[$];
   int          fv_cnt = 0, fd_cnt = 0, fd_cyc = 0, fv_last = 0;
   bit          fd_prev = 1'b0, busy_after_done = 1'b1;

   always @(negedge clk) begin
      if (rstN) begin
         if (window_out_valid) wins.push_back(window_out);
         if (filt_valid) begin fv_cnt++; fv_last = cyc; end
         if (fd_prev) busy_after_done = busy;
         fd_prev = frame_done;
         if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
         if (busy) rdy_log.push_back(pix_in_ready);
      end
   end

   int n_cmp = 0;
   int n_fail = 0;
   int img [H][W];

   function automatic logic [71:0] exp_win(int r, int c);
      logic [71:0] w = '0;
      for (int i = 0; i < 9; i++) begin
         int rr = r - 1 + i / 3;
         int cc = c - 1 + i % 3;
         if (rr >= 0 && rr < H && cc >= 0 && cc < W) w[i*8 +: 8] = img[rr][cc][7:0];
      end
      return w;
   endfunction

   function automatic int gauss(logic [71:0] w);
      int k [9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
      int s = 0;
      for (int i = 0; i < 9; i++) s += k[i] * int'(w[i*8 +: 8]);
      return s >> 4;
   endfunction

   task automatic set_ramp();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 4 * r + c + 1;
   endtask

   task automatic run_frame(input bit gaps, input int start_at, output bit err_next);
      int k = 0, guard = 0;
      bit rdy, pulsed = 1'b0;
      err_next = 1'b0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (k < N && guard < 1000) begin
         rdy          = pix_in_ready;
         pix_in       = img[k / W][k % W][7:0];
         pix_in_valid = gaps ? ($urandom_range(0, 99) < 60) : 1'b1;
         start        = (k == start_at) && !pulsed;
         if (start) pulsed = 1'b1;
         @(posedge clk); #1;
`ifdef GAUSS_CTRL_ERR_EN
         if (start) err_next = err;
`endif
         start = 1'b0;
         if (rdy && pix_in_valid) k++;
         guard++;
      end
      pix_in_valid = 1'b0;
      n_cmp++;
      if (k !== N) begin
         n_fail++;
         $display("FAIL feed_timeout: accepted %0d pixels, required %0d", k, N);
      end
      guard = 0;
      while (!frame_done && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      n_cmp++;
      if (frame_done !== 1'b1) begin
         n_fail++;
         $display("FAIL frame_done_timeout: frame_done=%b, required 1", frame_done);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      n_cmp += 5;
      if (pix_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", pix_in_ready); end
      if (window_out !== 72'd0) begin n_fail++; $display("FAIL rst_window: got %h want 0", window_out); end
      if (window_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", window_out_valid); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", frame_done); end
`ifdef GAUSS_CTRL_ERR_EN
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
`endif
   endtask

   task automatic test_corner_windows();
      int w0 = wins.size();
      bit e;
      set_ramp();
      run_frame(1'b0, -1, e);
      n_cmp++;
      if (wins.size() - w0 !== N) begin
         n_fail++; $display("FAIL corner_count: got %0d want %0d", wins.size() - w0, N);
      end
      if (wins.size() - w0 >= N) begin
         n_cmp += 3;
         if (wins[w0] !== 72'h060500020100000000) begin
            n_fail++; $display("FAIL first_window: got %h want 060500020100000000", wins[w0]);
         end
         if (wins[w0+5] !== 72'h0B0A09070605030201) begin
            n_fail++; $display("FAIL window_1_1: got %h want 0B0A09070605030201", wins[w0+5]);
         end
         if (wins[w0+11] !== 72'h000000000C0B000807) begin
            n_fail++; $display("FAIL last_window: got %h want 000000000C0B000807", wins[w0+11]);
         end
         for (int i = 0; i < N; i++) begin
            n_cmp++;
            if (wins[w0+i] !== exp_win(i / W, i % W)) begin
               n_fail++; $display("FAIL corner_win%0d: got %h want %h", i, wins[w0+i], exp_win(i / W, i % W));
            end
         end
      end
   endtask

   task automatic test_ready_pattern();
      int r0 = rdy_log.size();
      int fv0 = fv_cnt, fd0 = fd_cnt;
      bit e, exp_r;
      set_ramp();
      run_frame(1'b0, -1, e);
      n_cmp++;
      if (rdy_log.size() - r0 < 20) begin
         n_fail++; $display("FAIL ready_len: got %0d busy cycles want >=20", rdy_log.size() - r0);
      end else begin
         for (int j = 0; j < 20; j++) begin
            exp_r = (j < 15) ? (j % 5 != 4) : 1'b0;
            n_cmp++;
            if (rdy_log[r0+j] !== exp_r) begin
               n_fail++; $display("FAIL ready_cyc%0d: got %b want %b", j, rdy_log[r0+j], exp_r);
            end
         end
      end
      n_cmp += 4;
      if (fv_cnt - fv0 !== N) begin n_fail++; $display("FAIL filt_count: got %0d want %0d", fv_cnt - fv0, N); end
      if (fd_cnt - fd0 !== 1) begin n_fail++; $display("FAIL done_count: got %0d want 1", fd_cnt - fd0); end
      if (fd_cyc !== fv_last + 1) begin n_fail++; $display("FAIL done_cycle: got %0d want %0d", fd_cyc, fv_last + 1); end
      if (busy_after_done !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy_after_done); end
   endtask

   task automatic test_random_gaps();
      bit e;
      set_ramp();
      for (int f = 0; f < 2; f++) begin
         int w0 = wins.size();
         run_frame(1'b1, -1, e);
         n_cmp++;
         if (wins.size() - w0 !== N) begin
            n_fail++; $display("FAIL gaps_count%0d: got %0d want %0d", f, wins.size() - w0, N);
         end
         for (int i = 0; i < N && w0 + i < wins.size(); i++) begin
            n_cmp++;
            if (wins[w0+i] !== exp_win(i / W, i % W)) begin
               n_fail++; $display("FAIL gaps_win%0d_%0d: got %h want %h", f, i, wins[w0+i], exp_win(i / W, i % W));
            end
         end
      end
   endtask

   task automatic test_constant();
      int w0 = wins.size();
      bit e;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 16;
      run_frame(1'b0, -1, e);
      n_cmp++;
      if (wins.size() - w0 !== N) begin
         n_fail++; $display("FAIL const_count: got %0d want %0d", wins.size() - w0, N);
      end else begin
         n_cmp += 3;
         if (gauss(wins[w0+5]) !== 16) begin n_fail++; $display("FAIL const_1_1: got %0d want 16", gauss(wins[w0+5])); end
         if (gauss(wins[w0+6]) !== 16) begin n_fail++; $display("FAIL const_1_2: got %0d want 16", gauss(wins[w0+6])); end
         if (gauss(wins[w0]) !== 9) begin n_fail++; $display("FAIL const_0_0: got %0d want 9", gauss(wins[w0])); end
      end
   endtask

   task automatic test_reset_mid();
      int k = 0, guard = 0, w0;
      bit rdy, e;
      set_ramp();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (k < 6 && guard < 100) begin
         rdy = pix_in_ready;
         pix_in = img[k / W][k % W][7:0];
         pix_in_valid = 1'b1;
         @(posedge clk); #1;
         if (rdy) k++;
         guard++;
      end
      pix_in_valid = 1'b0;
      rstN = 1'b0;
      @(posedge clk); #1;
      n_cmp += 5;
      if (pix_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: got %b want 0", pix_in_ready); end
      if (window_out !== 72'd0) begin n_fail++; $display("FAIL mid_window: got %h want 0", window_out); end
      if (window_out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b want 0", window_out_valid); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      if (frame_done !== 1'b0) begin n_fail++; $display("FAIL mid_done: got %b want 0", frame_done); end
      rstN = 1'b1;
      w0 = wins.size();
      repeat (10) @(posedge clk);
      #1;
      n_cmp++;
      if (wins.size() !== w0) begin n_fail++; $display("FAIL mid_quiet: got %0d windows want 0", wins.size() - w0); end
      run_frame(1'b0, -1, e);
      n_cmp++;
      if (wins.size() - w0 !== N) begin n_fail++; $display("FAIL mid_count: got %0d want %0d", wins.size() - w0, N); end
      for (int i = 0; i < N && w0 + i < wins.size(); i++) begin
         n_cmp++;
         if (wins[w0+i] !== exp_win(i / W, i % W)) begin
            n_fail++; $display("FAIL mid_win%0d: got %h want %h", i, wins[w0+i], exp_win(i / W, i % W));
         end
      end
   endtask

`ifdef GAUSS_CTRL_ERR_EN
   task automatic test_protocol_err();
      int w0 = wins.size();
      bit e;
      set_ramp();
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", err); end
      run_frame(1'b0, 3, e);
      n_cmp += 3;
      if (e !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", e); end
      if (wins.size() - w0 !== N) begin n_fail++; $display("FAIL err_count: got %0d want %0d", wins.size() - w0, N); end
      if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
      rstN = 1'b0;
      @(posedge clk); #1;
      rstN = 1'b1;
      n_cmp++;
      if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
   endtask
`endif

   initial begin
      test_reset();
      test_corner_windows();
      test_ready_pattern();
      test_random_gaps();
      test_constant();
      test_reset_mid();
`ifdef GAUSS_CTRL_ERR_EN
      test_protocol_err();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
